// File: rtl/traffic_light_monitor_if.sv
// Lamp-bus link between a traffic-light signalisation source and its
// receive-side monitor.
//   led_in     : 3-bit active-low lamp bus (110 red, 010 yellow, 011 green)
//   fault_clr  : single-cycle pulse clearing fault / fault_code
//   phase      : decoded phase (00 unknown, 01 red, 10 yellow, 11 green)
//   locked     : dwell checking active
//   cycle_done : pulse on a fully verified green -> red transition
//   fault      : sticky fault flag
//   fault_code : cause of first fault since last clear
//   err_count  : saturating fault count since reset
// master = stimulus / lamp side, slave = monitor.
interface traffic_light_monitor_if;
  logic [2:0] led_in;
  logic       fault_clr;
  logic [1:0] phase;
  logic       locked;
  logic       cycle_done;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] err_count;

  modport master (
    output led_in, fault_clr,
    input  phase, locked, cycle_done, fault, fault_code, err_count
  );

  modport slave (
    input  led_in, fault_clr,
    output phase, locked, cycle_done, fault, fault_code, err_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light lamp bus. Synchronises the
// active-low lamp bus, decodes it into a phase, checks the phase order
// (red -> yellow -> green -> red) and each phase's dwell time against
// expected cycle counts, and reports faults (sticky flag, first-fault code,
// saturating counter).
// Ports:
//   sys_clk   : single clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : traffic_light_monitor_if.slave (lamp input + status outputs)
// Latency from a led_in change to phase/fault/cycle_done is 3 clocks.
module traffic_light_monitor #(
  parameter int unsigned RED_CYC = 240_000_000,
  parameter int unsigned YEL_CYC = 48_000_000,
  parameter int unsigned GRN_CYC = 120_000_000,
  parameter int unsigned TOL_CYC = 4
) (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_RED  = 2'd1,
    PH_YEL  = 2'd2,
    PH_GRN  = 2'd3
  } phase_e;

  typedef enum logic {
    ACQ,
    LOCK
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ILLEGAL = 3'd1,
    FC_ORDER   = 3'd2,
    FC_SHORT   = 3'd3,
    FC_LONG    = 3'd4
  } fcode_e;

  logic [2:0]  s1, s2, prev;
  logic        change;
  phase_e      dec_phase;
  logic        dec_legal;
  logic [31:0] dwell;
  logic [31:0] exp_cyc, lo_lim, hi_lim;

  state_e      state, state_nx;
  phase_e      phase_lock, phase_succ;
  logic        grn_seen;
  fcode_e      cause;
  logic        step_ok;

  phase_e      phase_q, phase_d;
  logic        cycle_done_q, cycle_done_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  err_q, err_d;

  // Input path: 2-flop synchroniser, prev register, dwell counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      dwell <= '0;
    end else begin
      s1   <= bus.led_in;
      s2   <= s1;
      prev <= s2;
      if (change)
        dwell <= 32'd1;
      else if (dwell != '1)
        dwell <= dwell + 32'd1;
    end
  end

  // At a change event dwell still holds the length of the exiting pattern.
  assign change = (s2 != prev);

  always_comb begin
    dec_phase = PH_NONE;
    dec_legal = 1'b1;
    case (s2)
      3'b110:  dec_phase = PH_RED;
      3'b010:  dec_phase = PH_YEL;
      3'b011:  dec_phase = PH_GRN;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (phase_lock)
      PH_RED:  exp_cyc = 32'(RED_CYC);
      PH_YEL:  exp_cyc = 32'(YEL_CYC);
      PH_GRN:  exp_cyc = 32'(GRN_CYC);
      default: exp_cyc = '0;
    endcase
    lo_lim = (exp_cyc > 32'(TOL_CYC)) ? exp_cyc - 32'(TOL_CYC) : '0;
    hi_lim = exp_cyc + 32'(TOL_CYC);
  end

  always_comb begin
    case (phase_lock)
      PH_RED:  phase_succ = PH_YEL;
      PH_YEL:  phase_succ = PH_GRN;
      PH_GRN:  phase_succ = PH_RED;
      default: phase_succ = PH_NONE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= ACQ;
    else
      state <= state_nx;
  end

  // Next state and per-cycle checks.
  always_comb begin
    state_nx = state;
    cause    = FC_NONE;
    step_ok  = 1'b0;
    case (state)
      ACQ: begin
        if (change && dec_legal)
          state_nx = LOCK;
      end
      LOCK: begin
        if (!dec_legal)
          cause = FC_ILLEGAL;
        else if (change) begin
          if (dec_phase != phase_succ)
            cause = FC_ORDER;
          else if (dwell < lo_lim)
            cause = FC_SHORT;
          else if (dwell > hi_lim)
            cause = FC_LONG;
          else
            step_ok = 1'b1;
        end else if (dwell == hi_lim + 32'd1)
          cause = FC_LONG;
        if (cause != FC_NONE)
          state_nx = ACQ;
      end
      default: state_nx = ACQ;
    endcase
  end

  // Output next-values. A new fault beats a coincident fault_clr.
  always_comb begin
    phase_d      = dec_phase;
    cycle_done_d = step_ok && (phase_lock == PH_GRN) && grn_seen;
    fault_d      = fault_q;
    code_d       = code_q;
    err_d        = err_q;
    if (cause != FC_NONE) begin
      fault_d = 1'b1;
      if ((code_q == 3'd0) || bus.fault_clr)
        code_d = cause;
      if (err_q != '1)
        err_d = err_q + 8'd1;
    end else if (bus.fault_clr) begin
      fault_d = 1'b0;
      code_d  = '0;
    end
  end

  // grn_seen marks a green entered while already locked; a lock that lands
  // directly in green must not produce cycle_done on the following red.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_lock   <= PH_NONE;
      grn_seen     <= 1'b0;
      phase_q      <= PH_NONE;
      cycle_done_q <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= '0;
      err_q        <= '0;
    end else begin
      if (state == ACQ && state_nx == LOCK) begin
        phase_lock <= dec_phase;
        grn_seen   <= 1'b0;
      end else if (step_ok) begin
        phase_lock <= dec_phase;
        grn_seen   <= (dec_phase == PH_GRN);
      end
      phase_q      <= phase_d;
      cycle_done_q <= cycle_done_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      err_q        <= err_d;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.locked     = (state == LOCK);
  assign bus.cycle_done = cycle_done_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam int unsigned P_RED = 10;
  localparam int unsigned P_YEL = 2;
  localparam int unsigned P_GRN = 5;
  localparam int unsigned P_TOL = 1;

  localparam logic [2:0] L_RED = 3'b110;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b011;
  localparam logic [2:0] L_OFF = 3'b111;

  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic       cd;
    logic       fault;
    logic [2:0] code;
    logic [7:0] err;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cd_seen;
  string cur_test;

  obs_t sb[$];

  // Reference model state (input-time view of the monitor).
  logic [2:0]  m_d0, m_d1, m_pp;
  int unsigned m_run;
  logic        m_lock, m_gflag, m_fault;
  logic [1:0]  m_pl;
  logic [2:0]  m_code;
  int unsigned m_err;

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(
    .RED_CYC(P_RED),
    .YEL_CYC(P_YEL),
    .GRN_CYC(P_GRN),
    .TOL_CYC(P_TOL)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [1:0] dec(input logic [2:0] p);
    case (p)
      3'b110:  return 2'd1;
      3'b010:  return 2'd2;
      3'b011:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int unsigned exp_of(input logic [1:0] ph);
    case (ph)
      2'd1:    return P_RED;
      2'd2:    return P_YEL;
      2'd3:    return P_GRN;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] ph);
    return (ph == 2'd3) ? 2'd1 : ph + 2'd1;
  endfunction

  task automatic model_reset();
    m_d0 = '0; m_d1 = '0; m_pp = '0; m_run = 0;
    m_lock = 1'b0; m_gflag = 1'b0; m_fault = 1'b0;
    m_pl = '0; m_code = '0; m_err = 0;
    sb.delete();
  endtask

  // Advance the model by one driven cycle and push the outputs expected
  // after the edge that evaluates this cycle's inputs (led_in seen 2 clocks late).
  task automatic model_step(input logic [2:0] p, input logic clr);
    logic [2:0]  x;
    logic        chg;
    int unsigned held;
    logic [2:0]  cause;
    logic        cd;
    obs_t        e;
    x = m_d1; m_d1 = m_d0; m_d0 = p;
    chg = (x != m_pp);
    m_pp = x;
    held = m_run;
    m_run = chg ? 1 : m_run + 1;
    cause = 3'd0;
    cd = 1'b0;
    if (m_lock) begin
      if (dec(x) == 2'd0) cause = 3'd1;
      else if (chg) begin
        if (dec(x) != succ(m_pl)) cause = 3'd2;
        else if (held + P_TOL < exp_of(m_pl)) cause = 3'd3;
        else if (held > exp_of(m_pl) + P_TOL) cause = 3'd4;
        else begin
          cd = (m_pl == 2'd3) && m_gflag;
          m_gflag = (dec(x) == 2'd3);
          m_pl = dec(x);
        end
      end else if (m_run == exp_of(m_pl) + P_TOL + 2) cause = 3'd4;
    end else if (chg && dec(x) != 2'd0) begin
      m_lock = 1'b1; m_pl = dec(x); m_gflag = 1'b0;
    end
    if (cause != 3'd0) begin
      m_lock = 1'b0;
      m_fault = 1'b1;
      if (m_code == 3'd0 || clr) m_code = cause;
      if (m_err < 255) m_err++;
    end else if (clr) begin
      m_fault = 1'b0;
      m_code = 3'd0;
    end
    e.phase = dec(x); e.locked = m_lock; e.cd = cd; e.fault = m_fault;
    e.code = m_code; e.err = 8'(m_err);
    sb.push_back(e);
  endtask

  task automatic drive_step(input logic [2:0] p, input logic clr);
    bus.led_in = p;
    bus.fault_clr = clr;
    model_step(p, clr);
  endtask

  // One clock: compare the DUT against the oldest expectation, then drive.
  task automatic cycle(input logic [2:0] p, input logic clr);
    obs_t e, got;
    @(negedge clk);
    got = {bus.phase, bus.locked, bus.cycle_done, bus.fault, bus.fault_code, bus.err_count};
    if (bus.cycle_done === 1'b1) cd_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s sb t=%0t: got %h want %h", cur_test, $time, got, e);
      end
    end
    drive_step(p, clr);
  endtask

  task automatic seg(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(p, 1'b0);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    cur_test = "reset";
    bus.led_in = L_OFF; bus.fault_clr = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.phase, bus.locked, bus.cycle_done, bus.fault, bus.fault_code, bus.err_count};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got %h want 0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_step(L_OFF, 1'b0);
    seg(L_OFF, 3);
  endtask

  task automatic test_nominal();
    cur_test = "nominal";
    cd_seen = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(L_RED, 1'b0);
      if (i == 2) begin
        checks++;
        if (bus.locked !== 1'b0) begin
          errors++; $display("FAIL lock_early: got %b want 0", bus.locked);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.locked !== 1'b1 || bus.phase !== 2'd1) begin
          errors++; $display("FAIL lock_rise: got %b/%h want 1/1", bus.locked, bus.phase);
        end
      end
    end
    for (int per = 0; per < 3; per++) begin
      seg(L_YEL, 2);
      seg(L_GRN, 5);
      seg(L_RED, 11);
    end
    checks++;
    if (cd_seen !== 3 || bus.err_count !== 8'd0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL nominal_summary: got cd=%0d err=%0d fault=%b want cd=3 err=0 fault=0",
               cd_seen, bus.err_count, bus.fault);
    end
  endtask

  task automatic test_illegal();
    cur_test = "illegal";
    seg(L_YEL, 2);
    seg(L_GRN, 2);
    cycle(L_OFF, 1'b0);
    seg(L_GRN, 3);
    checks++;
    if ({bus.fault, bus.fault_code, bus.err_count, bus.locked, bus.phase} !==
        {1'b1, 3'd1, 8'd1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL illegal_fault: got f=%b c=%0d e=%0d l=%b p=%0d want 1 1 1 0 0",
               bus.fault, bus.fault_code, bus.err_count, bus.locked, bus.phase);
    end
    cycle(L_GRN, 1'b0);
    checks++;
    if (bus.locked !== 1'b1 || bus.phase !== 2'd3) begin
      errors++; $display("FAIL illegal_relock: got %b/%0d want 1/3", bus.locked, bus.phase);
    end
    seg(L_RED, 11);
    seg(L_YEL, 2);
    seg(L_GRN, 5);
    seg(L_RED, 11);
  endtask

  task automatic test_wrong_order();
    cur_test = "wrong_order";
    cycle(L_YEL, 1'b1);
    cycle(L_YEL, 1'b0);
    checks++;
    if ({bus.fault, bus.fault_code, bus.err_count} !== {1'b0, 3'd0, 8'd1}) begin
      errors++;
      $display("FAIL clear_only: got f=%b c=%0d e=%0d want 0 0 1",
               bus.fault, bus.fault_code, bus.err_count);
    end
    seg(L_GRN, 5);
    seg(L_RED, 11);
    cycle(L_GRN, 1'b0);
    seg(L_GRN, 3);
    checks++;
    if ({bus.fault, bus.fault_code, bus.err_count, bus.locked} !== {1'b1, 3'd2, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL order_fault: got f=%b c=%0d e=%0d l=%b want 1 2 2 0",
               bus.fault, bus.fault_code, bus.err_count, bus.locked);
    end
    seg(L_GRN, 1);
    seg(L_RED, 11);
    seg(L_YEL, 2);
    seg(L_GRN, 2);
    cycle(L_RED, 1'b0);
    seg(L_RED, 3);
    checks++;
    if ({bus.fault, bus.fault_code, bus.err_count} !== {1'b1, 3'd2, 8'd3}) begin
      errors++;
      $display("FAIL first_kept: got f=%b c=%0d e=%0d want 1 2 3",
               bus.fault, bus.fault_code, bus.err_count);
    end
    seg(L_RED, 7);
    seg(L_YEL, 2);
    seg(L_GRN, 5);
    seg(L_RED, 11);
  endtask

  task automatic test_too_long();
    cur_test = "too_long";
    cycle(L_YEL, 1'b1);
    cycle(L_YEL, 1'b0);
    seg(L_GRN, 8);
    cycle(L_RED, 1'b0);
    cycle(L_RED, 1'b0);
    checks++;
    if (bus.err_count !== 8'd3 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL long_early: got e=%0d f=%b want 3 0", bus.err_count, bus.fault);
    end
    cycle(L_RED, 1'b0);
    checks++;
    if ({bus.fault, bus.fault_code, bus.err_count, bus.locked} !== {1'b1, 3'd4, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL long_fault: got f=%b c=%0d e=%0d l=%b want 1 4 4 0",
               bus.fault, bus.fault_code, bus.err_count, bus.locked);
    end
    seg(L_RED, 8);
    checks++;
    if (bus.err_count !== 8'd4 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL long_once: got e=%0d l=%b want 4 1", bus.err_count, bus.locked);
    end
    seg(L_YEL, 2);
    seg(L_GRN, 5);
    seg(L_RED, 11);
  endtask

  task automatic test_clr_collision();
    cur_test = "clr_collision";
    seg(L_YEL, 2);
    seg(L_GRN, 2);
    for (int i = 0; i < 11; i++) begin
      cycle(L_RED, (i == 2) || (i == 5));
      if (i == 3) begin
        checks++;
        if ({bus.fault, bus.fault_code, bus.err_count} !== {1'b1, 3'd3, 8'd5}) begin
          errors++;
          $display("FAIL clr_vs_fault: got f=%b c=%0d e=%0d want 1 3 5",
                   bus.fault, bus.fault_code, bus.err_count);
        end
      end
      if (i == 6) begin
        checks++;
        if ({bus.fault, bus.fault_code, bus.err_count} !== {1'b0, 3'd0, 8'd5}) begin
          errors++;
          $display("FAIL clr_alone: got f=%b c=%0d e=%0d want 0 0 5",
                   bus.fault, bus.fault_code, bus.err_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    cur_test = "reset_mid";
    cycle(L_YEL, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    got = {bus.phase, bus.locked, bus.cycle_done, bus.fault, bus.fault_code, bus.err_count};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0000", got);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cd_seen = 0;
    drive_step(L_GRN, 1'b0);
    seg(L_GRN, 4);
    seg(L_RED, 11);
    checks++;
    if (cd_seen !== 0) begin
      errors++; $display("FAIL reset_no_cd: got %0d want 0", cd_seen);
    end
    seg(L_YEL, 2);
    seg(L_GRN, 5);
    seg(L_RED, 11);
    checks++;
    if (cd_seen !== 1 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_cd: got cd=%0d e=%0d want 1 0", cd_seen, bus.err_count);
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    for (int i = 0; i < 300; i++) begin
      cycle(L_OFF, 1'b0);
      cycle(L_GRN, 1'b0);
    end
    seg(L_GRN, 4);
    checks++;
    if ({bus.err_count, bus.fault, bus.fault_code} !== {8'd255, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL err_saturate: got e=%0d f=%b c=%0d want 255 1 1",
               bus.err_count, bus.fault, bus.fault_code);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cd_seen = 0;
    model_reset();
    test_reset();
    test_nominal();
    test_illegal();
    test_wrong_order();
    test_too_long();
    test_clr_collision();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
